// File: rtl/mips_pkg.sv
// Shared definitions for the shift sequencer: FSM state encoding and the
// shift-amount width.
package mips_pkg;

  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/response bus of the shift sequencer. The dir signal exists only
// when SHIFT_SEQUENCER_RIGHT_EN is defined.
interface shift_sequencer_if
  import mips_pkg::*;
#(
  parameter int width = 32
);

  logic               start;
  logic [width-1:0]   in;
  logic [SHAMT_W-1:0] shamt;
`ifdef SHIFT_SEQUENCER_RIGHT_EN
  logic               dir;
`endif
  logic               ready;
  logic               done;
  logic [width-1:0]   out;

`ifdef SHIFT_SEQUENCER_RIGHT_EN
  modport master (output start, in, shamt, dir, input ready, done, out);
  modport slave  (input start, in, shamt, dir, output ready, done, out);
`else
  modport master (output start, in, shamt, input ready, done, out);
  modport slave  (input start, in, shamt, output ready, done, out);
`endif

endinterface

// File: rtl/shift_left_twice.sv
// Combinational left shift by two with zero fill.
module shift_left_twice #(
  parameter int width = 32
) (
  input  logic [width-1:0] in,
  output logic [width-1:0] out
);

  assign out = {in[width-3:0], 2'b00};

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle barrel-free shifter: shifts an operand by up to 31 bits,
// two bits per cycle (one bit for an odd remainder), then presents the
// result with a one-cycle done pulse.
// Optional feature: define SHIFT_SEQUENCER_RIGHT_EN to add a dir input
// selecting logical right shifts with the same schedule.
module shift_sequencer
  import mips_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  shift_sequencer_if.slave bus
);

  state_t             state, state_next;
  logic [width-1:0]   acc, acc_next, acc_sl2;
  logic [width-1:0]   out_reg, out_next;
  logic [SHAMT_W-1:0] rem, rem_next;
  logic               done_reg, done_next;
`ifdef SHIFT_SEQUENCER_RIGHT_EN
  logic               dir_reg, dir_next;
`endif

  shift_left_twice #(.width(width)) u_sl2 (
    .in  (acc),
    .out (acc_sl2)
  );

  // Next-state and datapath update; the unused encoding 2'd3 behaves as IDLE.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    rem_next   = rem;
    out_next   = out_reg;
    done_next  = 1'b0;
`ifdef SHIFT_SEQUENCER_RIGHT_EN
    dir_next   = dir_reg;
`endif
    case (state)
      SHIFT: begin
        if (rem >= SHAMT_W'(2)) begin
`ifdef SHIFT_SEQUENCER_RIGHT_EN
          acc_next = dir_reg ? (acc >> 2) : acc_sl2;
`else
          acc_next = acc_sl2;
`endif
          rem_next = rem - SHAMT_W'(2);
        end else begin
`ifdef SHIFT_SEQUENCER_RIGHT_EN
          acc_next = dir_reg ? (acc >> 1) : {acc[width-2:0], 1'b0};
`else
          acc_next = {acc[width-2:0], 1'b0};
`endif
          rem_next = '0;
        end
        if (rem_next == '0) state_next = DONE;
      end
      DONE: begin
        out_next   = acc;
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        if (bus.start) begin
          acc_next   = bus.in;
          rem_next   = bus.shamt;
          out_next   = '0;
          state_next = (bus.shamt == '0) ? DONE : SHIFT;
`ifdef SHIFT_SEQUENCER_RIGHT_EN
          dir_next   = bus.dir;
`endif
        end
      end
    endcase
  end

  // State and datapath registers; reset clears everything and aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      rem      <= '0;
      out_reg  <= '0;
      done_reg <= 1'b0;
`ifdef SHIFT_SEQUENCER_RIGHT_EN
      dir_reg  <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      acc      <= acc_next;
      rem      <= rem_next;
      out_reg  <= out_next;
      done_reg <= done_next;
`ifdef SHIFT_SEQUENCER_RIGHT_EN
      dir_reg  <= dir_next;
`endif
    end
  end

  assign bus.ready = (state != SHIFT) && (state != DONE);
  assign bus.done  = done_reg;
  assign bus.out   = out_reg;

endmodule
